// File: rtl/vis_acquire_ctrl_pkg.sv
// Shared definitions for the acquisition sequencer: state encoding and the status-word
// bit positions used by the bus register map.
package vis_acquire_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArm   = 2'd1,
        StRun   = 2'd2,
        StDrain = 2'd3
    } acq_state_e;

    localparam int unsigned StatusBusyBit     = 0;
    localparam int unsigned StatusDoneBit     = 1;
    localparam int unsigned StatusOverflowBit = 2;
    localparam int unsigned StatusBadCfgBit   = 3;

endpackage

// File: rtl/vis_acquire_ctrl.sv
// Acquisition sequencer: gates the signal-buffer stream into the correlator on block
// boundaries, issues whole frames of cfg_limit blocks and drains until all frames are out.
module vis_acquire_ctrl
    import vis_acquire_ctrl_pkg::*;
#(
    parameter int unsigned LBITS = 26,
    parameter int unsigned FBITS = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cfg_start_i,
    input  logic             cfg_stop_i,
    input  logic [LBITS-1:0] cfg_limit_i,
    input  logic [FBITS-1:0] cfg_frames_i,
    input  logic             buf_valid_i,
    input  logic             buf_first_i,
    input  logic             acc_valid_i,
    input  logic             acc_last_i,
    input  logic             acc_ready_i,
    output logic             cor_valid_o,
    output logic [LBITS-1:0] acc_limit_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o,
    output logic             bad_cfg_o,
    output logic [FBITS-1:0] frames_o
);

    acq_state_e       state_q, state_d;
    logic [LBITS-1:0] lim_q, lim_d;
    logic [LBITS-1:0] blk_q, blk_d;
    logic [FBITS-1:0] quota_q, quota_d;
    logic [FBITS-1:0] issued_q, issued_d;
    logic [FBITS-1:0] frames_q, frames_d;
    logic             overflow_q, overflow_d;
    logic             bad_cfg_q, bad_cfg_d;
    logic             stop_pend_q, stop_pend_d;
    logic             done_q, done_d;

    logic boundary, fend, quota_hit, close, frame_out, ovf_evt;

    assign boundary  = buf_valid_i & buf_first_i;
    assign fend      = boundary & (blk_q == lim_q - LBITS'(1));
    assign quota_hit = (quota_q != '0) & (issued_q == quota_q);
    // A stop arriving on the closing boundary itself still takes effect there.
    assign close     = (state_q == StRun) & fend
                     & (stop_pend_q | cfg_stop_i | overflow_q | quota_hit);
    assign frame_out = acc_valid_i & acc_last_i & acc_ready_i;
    assign ovf_evt   = acc_valid_i & ~acc_ready_i;

    assign cor_valid_o = buf_valid_i & (((state_q == StArm) & buf_first_i)
                                      | ((state_q == StRun) & ~close));
    assign acc_limit_o = lim_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign overflow_o  = overflow_q;
    assign bad_cfg_o   = bad_cfg_q;
    assign frames_o    = frames_q;

    always_comb begin
        state_d     = state_q;
        lim_d       = lim_q;
        blk_d       = blk_q;
        quota_d     = quota_q;
        issued_d    = issued_q;
        frames_d    = frames_q;
        overflow_d  = overflow_q | ovf_evt;
        bad_cfg_d   = bad_cfg_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;

        // Late frames are counted in every state, including IDLE.
        if (frame_out) begin
            frames_d = frames_q + FBITS'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (cfg_start_i) begin
                    if (cfg_limit_i != '0) begin
                        state_d     = StArm;
                        lim_d       = cfg_limit_i;
                        quota_d     = cfg_frames_i;
                        frames_d    = '0;
                        overflow_d  = ovf_evt;
                        bad_cfg_d   = 1'b0;
                        issued_d    = '0;
                        blk_d       = '0;
                        stop_pend_d = 1'b0;
                    end else begin
                        bad_cfg_d = 1'b1;
                    end
                end
            end
            StArm: begin
                if (cfg_stop_i) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (boundary) begin
                    // The opening boundary starts block 0 of the first frame.
                    state_d  = StRun;
                    issued_d = issued_q + FBITS'(1);
                    blk_d    = '0;
                end
            end
            StRun: begin
                if (close) begin
                    state_d     = StDrain;
                    stop_pend_d = 1'b0;
                end else begin
                    if (cfg_stop_i) begin
                        stop_pend_d = 1'b1;
                    end
                    if (boundary) begin
                        if (fend) begin
                            blk_d    = '0;
                            issued_d = issued_q + FBITS'(1);
                        end else begin
                            blk_d = blk_q + LBITS'(1);
                        end
                    end
                end
            end
            StDrain: begin
                if (frames_q == issued_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            lim_q       <= '0;
            blk_q       <= '0;
            quota_q     <= '0;
            issued_q    <= '0;
            frames_q    <= '0;
            overflow_q  <= 1'b0;
            bad_cfg_q   <= 1'b0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lim_q       <= lim_d;
            blk_q       <= blk_d;
            quota_q     <= quota_d;
            issued_q    <= issued_d;
            frames_q    <= frames_d;
            overflow_q  <= overflow_d;
            bad_cfg_q   <= bad_cfg_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_vis_acquire_ctrl.sv
// Bench for vis_acquire_ctrl: frame-level reference model compared every cycle, plus
// hand-computed end-of-scenario expectations.
module tb_vis_acquire_ctrl;

    localparam int unsigned LBITS = 26;
    localparam int unsigned FBITS = 16;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             cfg_start_i = 1'b0;
    logic             cfg_stop_i = 1'b0;
    logic [LBITS-1:0] cfg_limit_i = '0;
    logic [FBITS-1:0] cfg_frames_i = '0;
    logic             buf_valid_i = 1'b0;
    logic             buf_first_i = 1'b0;
    logic             acc_valid_i = 1'b0;
    logic             acc_last_i = 1'b0;
    logic             acc_ready_i = 1'b1;
    logic             cor_valid_o;
    logic [LBITS-1:0] acc_limit_o;
    logic             busy_o;
    logic             done_o;
    logic             overflow_o;
    logic             bad_cfg_o;
    logic [FBITS-1:0] frames_o;

    vis_acquire_ctrl #(
        .LBITS(LBITS),
        .FBITS(FBITS)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cfg_start_i (cfg_start_i),
        .cfg_stop_i  (cfg_stop_i),
        .cfg_limit_i (cfg_limit_i),
        .cfg_frames_i(cfg_frames_i),
        .buf_valid_i (buf_valid_i),
        .buf_first_i (buf_first_i),
        .acc_valid_i (acc_valid_i),
        .acc_last_i  (acc_last_i),
        .acc_ready_i (acc_ready_i),
        .cor_valid_o (cor_valid_o),
        .acc_limit_o (acc_limit_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o),
        .bad_cfg_o   (bad_cfg_o),
        .frames_o    (frames_o)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int blocks_seen = 0;

    // Frame-level model: phase plus total blocks passed since the gate opened.
    // Frames issued = ceil(passed / lim); a frame ends when passed is a multiple of lim.
    int m_mode = 0;   // 0 idle, 1 armed, 2 running, 3 draining
    int m_passed = 0;
    int m_lim = 0;
    int m_quota = 0;
    int m_frames = 0;
    bit m_ovf = 0;
    bit m_bad = 0;
    bit m_stop = 0;
    bit m_done = 0;

    function automatic int m_issued();
        if (m_lim == 0) return 0;
        return (m_passed + m_lim - 1) / m_lim;
    endfunction

    function automatic bit m_close();
        if (m_mode != 2 || !(buf_valid_i && buf_first_i) || m_lim == 0) return 0;
        if (m_passed % m_lim != 0) return 0;
        return m_stop || cfg_stop_i || m_ovf || (m_quota != 0 && m_issued() == m_quota);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        int  mode_n, passed_n, lim_n, quota_n, frames_n;
        bit  ovf_n, bad_n, stop_n, done_n, cls, accepted;
        if (!reset_n) begin
            m_mode <= 0; m_passed <= 0; m_lim <= 0; m_quota <= 0; m_frames <= 0;
            m_ovf <= 0; m_bad <= 0; m_stop <= 0; m_done <= 0;
        end else begin
            mode_n = m_mode; passed_n = m_passed; lim_n = m_lim; quota_n = m_quota;
            frames_n = m_frames; ovf_n = m_ovf; bad_n = m_bad; stop_n = m_stop;
            done_n = 0; accepted = 0;
            cls = m_close();
            case (m_mode)
                0: if (cfg_start_i) begin
                    if (cfg_limit_i != 0) begin
                        accepted = 1; mode_n = 1; lim_n = int'(cfg_limit_i);
                        quota_n = int'(cfg_frames_i); passed_n = 0; ovf_n = 0; bad_n = 0;
                        stop_n = 0;
                    end else begin
                        bad_n = 1;
                    end
                end
                1: if (cfg_stop_i) begin
                    mode_n = 0; done_n = 1;
                end else if (buf_valid_i && buf_first_i) begin
                    mode_n = 2; passed_n = 1;
                end
                2: if (cls) begin
                    mode_n = 3; stop_n = 0;
                end else begin
                    if (buf_valid_i && buf_first_i) passed_n = m_passed + 1;
                    if (cfg_stop_i) stop_n = 1;
                end
                default: if (m_frames == m_issued()) begin
                    mode_n = 0; done_n = 1;
                end
            endcase
            if (accepted) frames_n = 0;
            else if (acc_valid_i && acc_last_i && acc_ready_i) frames_n = (m_frames + 1) % 65536;
            if (acc_valid_i && !acc_ready_i) ovf_n = 1;
            m_mode <= mode_n; m_passed <= passed_n; m_lim <= lim_n; m_quota <= quota_n;
            m_frames <= frames_n; m_ovf <= ovf_n; m_bad <= bad_n; m_stop <= stop_n;
            m_done <= done_n;
        end
    end

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start(input int unsigned limit, input int unsigned frames);
        cfg_limit_i  = LBITS'(limit);
        cfg_frames_i = FBITS'(frames);
        cfg_start_i  = 1'b1;
        tick(1);
        cfg_start_i  = 1'b0;
    endtask

    // One 15-cycle block: boundary on cycle 0, five valid samples. emit=1 sends an accumulator
    // frame, emit=2 a one-cycle backpressure hit; stop_mid pulses stop on cycle 10.
    task automatic block(input int emit, input bit stop_mid);
        for (int c = 0; c < 15; c++) begin
            buf_valid_i = (c < 5);
            buf_first_i = (c == 0);
            cfg_stop_i  = stop_mid && (c == 10);
            acc_valid_i = (emit != 0) && (c == 7 || c == 8);
            acc_last_i  = (emit == 1) && (c == 8);
            acc_ready_i = !(emit == 2 && c == 8);
            tick(1);
        end
        buf_valid_i = 1'b0; buf_first_i = 1'b0; cfg_stop_i = 1'b0;
        acc_valid_i = 1'b0; acc_last_i = 1'b0; acc_ready_i = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o && n < 300) begin
            tick(1);
            n++;
        end
        check(name, busy_o, 0);
        tick(2);
    endtask

    task automatic clear_counts();
        done_seen = 0;
        blocks_seen = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork
            forever begin
                @(negedge clock);
                check("cor_valid", cor_valid_o, buf_valid_i && ((m_mode == 1 && buf_first_i)
                                                 || (m_mode == 2 && !m_close())));
                check("acc_limit", acc_limit_o, m_lim);
                check("busy", busy_o, m_mode != 0);
                check("done", done_o, m_done);
                check("overflow", overflow_o, m_ovf);
                check("bad_cfg", bad_cfg_o, m_bad);
                check("frames", frames_o, m_frames);
                if (done_o) done_seen++;
                if (cor_valid_o && buf_first_i) blocks_seen++;
            end
        join_none

        tick(1);
        check("rst_busy", busy_o, 0);
        check("rst_limit", acc_limit_o, 0);
        check("rst_frames", frames_o, 0);
        check("rst_flags", {done_o, overflow_o, bad_cfg_o, cor_valid_o}, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // lim=3, two frames: six blocks pass, seventh boundary closes the gate.
        clear_counts();
        start(3, 2);
        tick(2);
        for (int b = 1; b <= 7; b++) block((b == 4 || b == 7) ? 1 : 0, 1'b0);
        wait_idle("t1_idle");
        check("t1_blocks", blocks_seen, 6);
        check("t1_done", done_seen, 1);
        check("t1_frames", frames_o, 2);
        check("t1_limit", acc_limit_o, 3);

        // Continuous, lim=2, stop during block 3: closes at boundary 5.
        clear_counts();
        start(2, 0);
        for (int b = 1; b <= 5; b++) block((b == 3 || b == 5) ? 1 : 0, b == 3);
        wait_idle("t2_idle");
        check("t2_blocks", blocks_seen, 4);
        check("t2_done", done_seen, 1);
        check("t2_frames", frames_o, 2);

        // Zero limit is rejected; the next good start clears the flag.
        clear_counts();
        start(0, 5);
        check("t3_bad", bad_cfg_o, 1);
        check("t3_busy", busy_o, 0);
        block(0, 1'b0);
        check("t3_gate_shut", blocks_seen, 0);
        start(1, 1);
        check("t3_bad_clr", bad_cfg_o, 0);
        block(0, 1'b0);
        block(1, 1'b0);
        wait_idle("t3_idle");
        check("t3_blocks", blocks_seen, 1);
        check("t3_frames", frames_o, 1);
        check("t3_done", done_seen, 1);

        // Backpressure in RUN with lim=4: close at the end of the current frame.
        clear_counts();
        start(4, 0);
        block(0, 1'b0);
        block(2, 1'b0);
        check("t4_ovf_set", overflow_o, 1);
        for (int b = 3; b <= 5; b++) block((b == 5) ? 1 : 0, 1'b0);
        wait_idle("t4_idle");
        check("t4_blocks", blocks_seen, 4);
        check("t4_frames", frames_o, 1);
        check("t4_ovf", overflow_o, 1);
        check("t4_done", done_seen, 1);

        // Stop while armed: no frame issued.
        clear_counts();
        start(2, 1);
        tick(3);
        cfg_stop_i = 1'b1;
        tick(1);
        cfg_stop_i = 1'b0;
        tick(3);
        check("t5_busy", busy_o, 0);
        check("t5_done", done_seen, 1);
        check("t5_blocks", blocks_seen, 0);
        check("t5_frames", frames_o, 0);

        // Asynchronous reset mid-RUN, then a fresh acquisition.
        start(2, 0);
        block(0, 1'b0);
        block(0, 1'b0);
        block(1, 1'b0);
        buf_valid_i = 1'b1; buf_first_i = 1'b1;
        tick(1);
        buf_first_i = 1'b0;
        tick(1);
        check("t6_pre_busy", busy_o, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_cor_valid", cor_valid_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_limit", acc_limit_o, 0);
        check("t6_frames", frames_o, 0);
        check("t6_flags", {done_o, overflow_o, bad_cfg_o}, 0);
        buf_valid_i = 1'b0;
        @(posedge clock);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        clear_counts();
        start(1, 1);
        block(0, 1'b0);
        block(1, 1'b0);
        wait_idle("t6_idle");
        check("t6_blocks", blocks_seen, 1);
        check("t6_frames_new", frames_o, 1);
        check("t6_done", done_seen, 1);
        check("t6_limit_new", acc_limit_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
